// File: rtl/dna_pkg.sv
// dna_pkg: shared definitions for the DNA storage encoder/decoder pair.
//   - ASCII nucleotide letters and their 2-bit codes (A=00, C=01, G=10, T=11)
//   - code_to_letter(): 2-bit code -> 8-bit ASCII letter
//   - bin_to_dna FSM state type
package dna_pkg;

  localparam logic [7:0] LTR_A = 8'h41;
  localparam logic [7:0] LTR_C = 8'h43;
  localparam logic [7:0] LTR_G = 8'h47;
  localparam logic [7:0] LTR_T = 8'h54;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_ENCODE       = 2'd1,
    ST_UPDATE_INDEX = 2'd2
  } b2d_state_t;

  function automatic logic [7:0] code_to_letter(input logic [1:0] code);
    logic [7:0] ltr;
    case (code)
      2'b00:   ltr = LTR_A;
      2'b01:   ltr = LTR_C;
      2'b10:   ltr = LTR_G;
      default: ltr = LTR_T;
    endcase
    return ltr;
  endfunction

endpackage

// File: rtl/bin_to_dna_if.sv
// bin_to_dna_if: job handshake and data bus of the bin_to_dna encoder.
//   start        level request, a job starts on its rising edge
//   binary_msg   message to encode (8*NUM_BYTES bits)
//   dna          encoded strand (40*NUM_BYTES bits)
//   busy         job in progress
//   finish_flag  job completed, held until next accepted start or reset
// master = job requester, slave = encoder.
interface bin_to_dna_if #(
  parameter int NUM_BYTES = 8
);
  logic                    start;
  logic [8*NUM_BYTES-1:0]  binary_msg;
  logic [40*NUM_BYTES-1:0] dna;
  logic                    busy;
  logic                    finish_flag;

  modport master (
    output start, binary_msg,
    input  dna, busy, finish_flag
  );

  modport slave (
    input  start, binary_msg,
    output dna, busy, finish_flag
  );
endinterface

// File: rtl/bin_to_dna_byte_to_letters.sv
// byte_to_letters: combinational mapping of one message byte to its five
// nucleotide letters {L0,L1,L2,L3,L4}, L0 in the top 8 bits.
//   byte_in  [7:0]   byte to encode
//   letters  [39:0]  five ASCII letters
// L2 is a link letter derived from L1, and L4 carries the low two bits as an
// offset from L2, so the decoder recovers b[1:0] as code(L4) - code(L2).
module byte_to_letters
  import dna_pkg::*;
#(
  parameter int LINK_OFFSET = 1
) (
  input  logic [7:0]  byte_in,
  output logic [39:0] letters
);

  logic [1:0] code_l1;
  logic [1:0] code_l2;
  logic [1:0] code_l4;

  // 2-bit adds wrap naturally, giving the mod-4 arithmetic
  assign code_l1 = byte_in[5:4];
  assign code_l2 = code_l1 + 2'(LINK_OFFSET);
  assign code_l4 = code_l2 + byte_in[1:0];

  assign letters = {code_to_letter(byte_in[7:6]),
                    code_to_letter(code_l1),
                    code_to_letter(code_l2),
                    code_to_letter(byte_in[3:2]),
                    code_to_letter(code_l4)};

endmodule

// File: rtl/bin_to_dna.sv
// bin_to_dna: encodes a NUM_BYTES-byte message into 5 ASCII nucleotides per
// byte, one byte per two cycles, MSB byte first.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    bin_to_dna_if slave (start, binary_msg, dna, busy, finish_flag)
//
// state           | meaning
// ----------------+-----------------------------------------------------
// ST_IDLE         | waiting for a start rising edge; outputs held
// ST_ENCODE       | write letters of msg byte[byte_index] to its dna slot
// ST_UPDATE_INDEX | step to next lower byte, or finish after byte 0
module bin_to_dna
  import dna_pkg::*;
#(
  parameter int NUM_BYTES   = 8,
  parameter int LINK_OFFSET = 1
) (
  input  logic       clk,
  input  logic       reset,
  bin_to_dna_if.slave bus
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int MSG_W = 8 * NUM_BYTES;
  localparam int DNA_W = 40 * NUM_BYTES;

  b2d_state_t       state, state_nxt;
  logic             start_d;
  logic [IDX_W-1:0] byte_index, byte_index_nxt;
  logic [MSG_W-1:0] msg_reg, msg_reg_nxt;
  logic [DNA_W-1:0] dna_reg, dna_nxt;
  logic             busy_reg, busy_nxt;
  logic             finish_reg, finish_nxt;

  logic [7:0]       cur_byte;
  logic [39:0]      cur_letters;

  assign cur_byte = msg_reg[byte_index*8 +: 8];

  byte_to_letters #(
    .LINK_OFFSET (LINK_OFFSET)
  ) u_byte_to_letters (
    .byte_in (cur_byte),
    .letters (cur_letters)
  );

  always_comb begin
    state_nxt      = state;
    byte_index_nxt = byte_index;
    msg_reg_nxt    = msg_reg;
    dna_nxt        = dna_reg;
    busy_nxt       = busy_reg;
    finish_nxt     = finish_reg;
    case (state)
      ST_IDLE: begin
        // start is only looked at here, so edges while busy are dropped
        if (bus.start && !start_d) begin
          msg_reg_nxt    = bus.binary_msg;
          dna_nxt        = '0;
          byte_index_nxt = IDX_W'(NUM_BYTES - 1);
          finish_nxt     = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        dna_nxt[byte_index*40 +: 40] = cur_letters;
        state_nxt                    = ST_UPDATE_INDEX;
      end
      ST_UPDATE_INDEX: begin
        if (byte_index != '0) begin
          byte_index_nxt = byte_index - IDX_W'(1);
          state_nxt      = ST_ENCODE;
        end else begin
          finish_nxt = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      start_d    <= 1'b0;
      byte_index <= '0;
      msg_reg    <= '0;
      dna_reg    <= '0;
      busy_reg   <= 1'b0;
      finish_reg <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_d    <= bus.start;
      byte_index <= byte_index_nxt;
      msg_reg    <= msg_reg_nxt;
      dna_reg    <= dna_nxt;
      busy_reg   <= busy_nxt;
      finish_reg <= finish_nxt;
    end
  end

  assign bus.dna         = dna_reg;
  assign bus.busy        = busy_reg;
  assign bus.finish_flag = finish_reg;

endmodule

// File: tb/tb_bin_to_dna.sv
// tb_bin_to_dna: directed + random self-checking bench for bin_to_dna.
// Expected strands come from a letter-table encoder model; results are also
// decoded back to binary and compared with the original message.
module tb_bin_to_dna;

  localparam int NB   = 8;
  localparam int LINK = 1;

  logic clk;
  logic reset;

  bin_to_dna_if #(.NUM_BYTES(NB)) bus ();

  bin_to_dna #(
    .NUM_BYTES   (NB),
    .LINK_OFFSET (LINK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [319:0] exp_q[$];
  logic [63:0]  msg_q[$];

  localparam logic [319:0] EXP_ZERO = {8{"AACAC"}};
  localparam logic [319:0] EXP_PAT  = {"TTATT", "ACGGC", "TGTCT", "AACAC",
                                       "TTATT", "ACGGC", "TGTCT", "AACAC"};
  localparam logic [63:0]  MSG_PAT  = 64'hFF1BE400FF1BE400;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ltr(input int c);
    logic [7:0] tbl [4];
    tbl = '{8'h41, 8'h43, 8'h47, 8'h54};
    return tbl[c % 4];
  endfunction

  function automatic int code_of(input logic [7:0] l);
    case (l)
      8'h41:   return 0;
      8'h43:   return 1;
      8'h47:   return 2;
      8'h54:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [319:0] enc_msg(input logic [63:0] m);
    logic [319:0] d;
    int c0, c1, c2, c3, c4;
    d = '0;
    for (int k = 0; k < NB; k++) begin
      c0 = int'(m[k*8+6 +: 2]);
      c1 = int'(m[k*8+4 +: 2]);
      c2 = (c1 + LINK) % 4;
      c3 = int'(m[k*8+2 +: 2]);
      c4 = (c2 + int'(m[k*8 +: 2])) % 4;
      d[k*40 +: 40] = {ltr(c0), ltr(c1), ltr(c2), ltr(c3), ltr(c4)};
    end
    return d;
  endfunction

  function automatic logic [63:0] dec_msg(input logic [319:0] d);
    logic [63:0] m;
    int c0, c1, c2, c3, c4;
    m = '0;
    for (int k = 0; k < NB; k++) begin
      c0 = code_of(d[k*40+32 +: 8]);
      c1 = code_of(d[k*40+24 +: 8]);
      c2 = code_of(d[k*40+16 +: 8]);
      c3 = code_of(d[k*40+8 +: 8]);
      c4 = code_of(d[k*40 +: 8]);
      m[k*8 +: 8] = {c0[1:0], c1[1:0], c3[1:0], 2'((c4 - c2 + 4) % 4)};
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One job with per-cycle latency checks. glitch: change binary_msg before
  // E0+3 and pulse start into E0+5. abort: reset at E0+7. hold: keep start high.
  task automatic run_job(input logic [63:0] msg, input bit glitch, input bit abort, input bit hold);
    logic [319:0] exp_full;
    logic [319:0] exp_part;
    logic [319:0] drop_d;
    logic [63:0]  drop_m;
    exp_full = enc_msg(msg);
    exp_q.push_back(exp_full);
    msg_q.push_back(msg);
    bus.binary_msg = msg;
    bus.start      = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    chk("e0_busy", bus.busy, 1);
    chk("e0_finish", bus.finish_flag, 0);
    chk("e0_dna_clear", bus.dna, 0);
    for (int n = 1; n <= 16; n++) begin
      if (glitch && n == 3) bus.binary_msg = ~msg;
      if (glitch && n == 5) bus.start = 1'b1;
      if (glitch && n == 6) bus.start = 1'b0;
      if (abort && n == 7) reset = 1'b1;
      step();
      if (abort && n == 7) begin
        chk("abort_dna", bus.dna, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_finish", bus.finish_flag, 0);
        reset  = 1'b0;
        drop_d = exp_q.pop_back();
        drop_m = msg_q.pop_back();
        return;
      end
      exp_part = '0;
      for (int k = 0; k < NB; k++)
        if (n >= 1 + 2*(NB-1-k)) exp_part[k*40 +: 40] = exp_full[k*40 +: 40];
      chk("job_dna", bus.dna, exp_part);
      chk("job_busy", bus.busy, (n < 16));
      chk("job_finish", bus.finish_flag, (n == 16));
    end
    chk("sb_dna", bus.dna, exp_q.pop_front());
    chk("sb_roundtrip", dec_msg(bus.dna), msg_q.pop_front());
  endtask

  task automatic idle_hold(input logic [319:0] exp_dna, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      chk("idle_dna", bus.dna, exp_dna);
      chk("idle_busy", bus.busy, 0);
      chk("idle_finish", bus.finish_flag, 1);
    end
  endtask

  initial begin
    logic [63:0]  msg;
    logic [319:0] exp_d;
    int           cyc;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.binary_msg = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_dna", bus.dna, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_finish", bus.finish_flag, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("nostart_dna", bus.dna, 0);
      chk("nostart_busy", bus.busy, 0);
      chk("nostart_finish", bus.finish_flag, 0);
    end

    // all-zero message
    run_job(64'h0, 1'b0, 1'b0, 1'b0);
    chk("zero_strand", bus.dna, EXP_ZERO);
    idle_hold(EXP_ZERO, 3);

    // mixed pattern
    run_job(MSG_PAT, 1'b0, 1'b0, 1'b0);
    chk("pat_strand", bus.dna, EXP_PAT);
    idle_hold(EXP_PAT, 3);

    // start re-pulsed while busy, message changed mid-job
    run_job(MSG_PAT, 1'b1, 1'b0, 1'b0);
    chk("glitch_strand", bus.dna, EXP_PAT);
    idle_hold(EXP_PAT, 4);

    // reset mid-job, then a clean job
    run_job(64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b0);
    step();
    chk("post_abort_busy", bus.busy, 0);
    chk("post_abort_dna", bus.dna, 0);
    run_job(64'hA5C3_0F96_7E18_D24B, 1'b0, 1'b0, 1'b0);
    idle_hold(enc_msg(64'hA5C3_0F96_7E18_D24B), 2);

    // start held high across the whole job must not retrigger
    run_job(64'h5A5A_F00F_3CC3_1234, 1'b0, 1'b0, 1'b1);
    idle_hold(enc_msg(64'h5A5A_F00F_3CC3_1234), 4);
    bus.start = 1'b0;
    step();

    // random round-trip
    for (int i = 0; i < 200; i++) begin
      msg = {$urandom, $urandom};
      exp_q.push_back(enc_msg(msg));
      msg_q.push_back(msg);
      bus.binary_msg = msg;
      bus.start      = 1'b1;
      step();
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.finish_flag && cyc < 40) begin
        step();
        cyc++;
      end
      chk("rt_done", bus.finish_flag, 1);
      chk("rt_latency", cyc, 16);
      exp_d = exp_q.pop_front();
      chk("rt_dna", bus.dna, exp_d);
      chk("rt_decode", dec_msg(bus.dna), msg_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
